// File: rtl/interp_raster_seq.sv
// interp_raster_seq: sequences the plane-equation interpolator bank for one
// polygon in one tile. It pulses each enabled interpolator's setup strobe in
// turn, waits out the setup settle time, then raster-scans the tile with a
// valid/ready pixel handshake toward shading.
// Optional scissor rectangle: define INTERP_RASTER_SEQ_SCISSOR_EN.
module interp_raster_seq #(
  parameter int NUM_ATTR  = 4,
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 32,
  parameter int SETUP_LAT = 2
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      poly_valid,
  output logic                                      poly_ready,
  input  logic [NUM_ATTR-1:0]                       attr_mask,
  input  logic signed [11:0]                        tile_x0,
  input  logic signed [11:0]                        tile_y0,
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
  input  logic                                      scissor_en,
  input  logic signed [11:0]                        sc_xmin,
  input  logic signed [11:0]                        sc_xmax,
  input  logic signed [11:0]                        sc_ymin,
  input  logic signed [11:0]                        sc_ymax,
`endif
  output logic [NUM_ATTR-1:0]                       setup_out,
  output logic [((NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1)-1:0] attr_sel,
  output logic signed [11:0]                        x_ps,
  output logic signed [11:0]                        y_ps,
  output logic                                      pix_valid,
  input  logic                                      pix_ready,
  output logic                                      pix_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam int SEL_W = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;
  localparam int COL_W = $clog2(TILE_W);
  localparam int ROW_W = $clog2(TILE_H);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_ATTR-1:0] pending_q, pending_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [11:0]         org_x_q, org_x_d, org_y_q, org_y_d;
  logic [NUM_ATTR-1:0] setup_out_q, setup_out_d;
  logic [SEL_W-1:0]    attr_sel_q, attr_sel_d;
  logic [11:0]         x_q, x_d, y_q, y_d;
  logic                pix_valid_q, pix_valid_d;
  logic                pix_last_q, pix_last_d;
  logic                poly_ready_q, poly_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Origin in effect: live inputs while accepting, captured copy afterwards.
  logic [11:0] org_x, org_y;
  assign org_x = (state_q == IDLE) ? tile_x0 : org_x_q;
  assign org_y = (state_q == IDLE) ? tile_y0 : org_y_q;

  // Next raster position after the current pixel.
  logic             at_col_end;
  logic [11:0]      nxt_x, nxt_y;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic             nxt_last;
  assign at_col_end = (col_q == COL_W'(TILE_W - 1));
  assign nxt_x      = at_col_end ? org_x_q : x_q + 12'd1;
  assign nxt_y      = at_col_end ? y_q + 12'd1 : y_q;
  assign nxt_col    = at_col_end ? '0 : col_q + COL_W'(1);
  assign nxt_row    = at_col_end ? row_q + ROW_W'(1) : row_q;
  assign nxt_last   = (nxt_col == COL_W'(TILE_W - 1)) && (nxt_row == ROW_W'(TILE_H - 1));

  // Lowest set bit of the mask being worked on (incoming mask at accept).
  logic [NUM_ATTR-1:0] pick_src, low_hot;
  logic [SEL_W-1:0]    low_idx;
  assign pick_src = (state_q == IDLE) ? attr_mask : pending_q;
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ATTR - 1; i >= 0; i--) begin
      if (pick_src[i]) low_idx = SEL_W'(i);
    end
    low_hot = NUM_ATTR'(1) << low_idx;
  end

  // Whether the origin pixel / next pixel lies inside the scissor window.
  logic first_in, next_in;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
  logic        sc_en_q, sc_en_d;
  logic [11:0] sc_xmin_q, sc_xmin_d, sc_xmax_q, sc_xmax_d;
  logic [11:0] sc_ymin_q, sc_ymin_d, sc_ymax_q, sc_ymax_d;
  logic        sc_en_c;
  logic [11:0] sc_xmin_c, sc_xmax_c, sc_ymin_c, sc_ymax_c;

  // Scissor window in effect, then inclusive signed containment tests.
  always_comb begin
    sc_en_c   = (state_q == IDLE) ? scissor_en : sc_en_q;
    sc_xmin_c = (state_q == IDLE) ? sc_xmin    : sc_xmin_q;
    sc_xmax_c = (state_q == IDLE) ? sc_xmax    : sc_xmax_q;
    sc_ymin_c = (state_q == IDLE) ? sc_ymin    : sc_ymin_q;
    sc_ymax_c = (state_q == IDLE) ? sc_ymax    : sc_ymax_q;
    first_in  = !sc_en_c ||
                (($signed(org_x) >= $signed(sc_xmin_c)) && ($signed(org_x) <= $signed(sc_xmax_c)) &&
                 ($signed(org_y) >= $signed(sc_ymin_c)) && ($signed(org_y) <= $signed(sc_ymax_c)));
    next_in   = !sc_en_c ||
                (($signed(nxt_x) >= $signed(sc_xmin_c)) && ($signed(nxt_x) <= $signed(sc_xmax_c)) &&
                 ($signed(nxt_y) >= $signed(sc_ymin_c)) && ($signed(nxt_y) <= $signed(sc_ymax_c)));
  end
`else
  assign first_in = 1'b1;
  assign next_in  = 1'b1;
`endif

  // Next-state and next-output logic for the sequencer.
  logic leave_setup, go_scan;
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    setup_out_d  = '0;
    attr_sel_d   = attr_sel_q;
    x_d          = x_q;
    y_d          = y_q;
    pix_valid_d  = pix_valid_q;
    pix_last_d   = pix_last_q;
    poly_ready_d = poly_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    leave_setup  = 1'b0;
    go_scan      = 1'b0;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
    sc_en_d   = sc_en_q;
    sc_xmin_d = sc_xmin_q;
    sc_xmax_d = sc_xmax_q;
    sc_ymin_d = sc_ymin_q;
    sc_ymax_d = sc_ymax_q;
`endif
    unique case (state_q)
      IDLE: if (poly_valid) begin
        org_x_d      = tile_x0;
        org_y_d      = tile_y0;
        poly_ready_d = 1'b0;
        busy_d       = 1'b1;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
        sc_en_d   = scissor_en;
        sc_xmin_d = sc_xmin;
        sc_xmax_d = sc_xmax;
        sc_ymin_d = sc_ymin;
        sc_ymax_d = sc_ymax;
`endif
        if (|attr_mask) begin
          state_d     = SETUP;
          setup_out_d = low_hot;
          attr_sel_d  = low_idx;
          pending_d   = attr_mask & ~low_hot;
        end else begin
          leave_setup = 1'b1;
        end
      end
      SETUP: if (|pending_q) begin
        setup_out_d = low_hot;
        attr_sel_d  = low_idx;
        pending_d   = pending_q & ~low_hot;
      end else begin
        leave_setup = 1'b1;
      end
      WAIT: if (cnt_q == 4'd0) go_scan = 1'b1;
            else cnt_d = cnt_q - 4'd1;
      // A skipped (invalid) pixel advances without waiting for pix_ready.
      SCAN: if (!pix_valid_q || pix_ready) begin
        if (pix_last_q) begin
          state_d     = DONE;
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          done_d      = 1'b1;
        end else begin
          col_d       = nxt_col;
          row_d       = nxt_row;
          x_d         = nxt_x;
          y_d         = nxt_y;
          pix_valid_d = next_in;
          pix_last_d  = nxt_last;
        end
      end
      DONE: begin
        state_d      = IDLE;
        poly_ready_d = 1'b1;
        busy_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (leave_setup) begin
      if (SETUP_LAT == 0) begin
        go_scan = 1'b1;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(SETUP_LAT - 1);
      end
    end
    if (go_scan) begin
      state_d     = SCAN;
      x_d         = org_x;
      y_d         = org_y;
      col_d       = '0;
      row_d       = '0;
      pix_valid_d = first_in;
      pix_last_d  = 1'b0;
    end
  end

  // State and registered outputs; reset aborts any polygon in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      cnt_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      setup_out_q  <= '0;
      attr_sel_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_valid_q  <= 1'b0;
      pix_last_q   <= 1'b0;
      poly_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
      sc_en_q   <= 1'b0;
      sc_xmin_q <= '0;
      sc_xmax_q <= '0;
      sc_ymin_q <= '0;
      sc_ymax_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
      state_q      <= state_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      setup_out_q  <= setup_out_d;
      attr_sel_q   <= attr_sel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_valid_q  <= pix_valid_d;
      pix_last_q   <= pix_last_d;
      poly_ready_q <= poly_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
      sc_en_q   <= sc_en_d;
      sc_xmin_q <= sc_xmin_d;
      sc_xmax_q <= sc_xmax_d;
      sc_ymin_q <= sc_ymin_d;
      sc_ymax_q <= sc_ymax_d;
`endif
    end
  end

  assign poly_ready = poly_ready_q;
  assign setup_out  = setup_out_q;
  assign attr_sel   = attr_sel_q;
  assign x_ps       = x_q;
  assign y_ps       = y_q;
  assign pix_valid  = pix_valid_q;
  assign pix_last   = pix_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_interp_raster_seq.sv
// Bench for interp_raster_seq: table of polygons with per-cycle setup and
// first-pixel timing, a pixel scoreboard, plus hand-written sequences for
// reset abort, back-to-back accept and a zero-latency small-tile instance.
module tb_interp_raster_seq;

  localparam int NA = 4;
  localparam int TW = 32;
  localparam int TH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Main instance (default parameters).
  logic        poly_valid = 1'b0;
  logic        poly_ready;
  logic [3:0]  attr_mask = '0;
  logic [11:0] tile_x0 = '0, tile_y0 = '0;
  logic [3:0]  setup_out;
  logic [1:0]  attr_sel;
  logic [11:0] x_ps, y_ps;
  logic        pix_valid, pix_last, busy, done;
  logic        pix_ready = 1'b0;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
  logic        sc_en = 1'b0;
  logic [11:0] sc_xmin = '0, sc_xmax = '0, sc_ymin = '0, sc_ymax = '0;
`endif

  interp_raster_seq u_dut (
    .clock(clock), .reset(reset),
    .poly_valid(poly_valid), .poly_ready(poly_ready), .attr_mask(attr_mask),
    .tile_x0(tile_x0), .tile_y0(tile_y0),
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
    .scissor_en(sc_en), .sc_xmin(sc_xmin), .sc_xmax(sc_xmax), .sc_ymin(sc_ymin), .sc_ymax(sc_ymax),
`endif
    .setup_out(setup_out), .attr_sel(attr_sel), .x_ps(x_ps), .y_ps(y_ps),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  // Zero-latency instance on a 4x2 tile with three interpolators.
  logic        z_poly_valid = 1'b0, z_poly_ready;
  logic [2:0]  z_mask = '0, z_setup;
  logic [1:0]  z_sel;
  logic [11:0] z_x0 = '0, z_y0 = '0, z_x, z_y;
  logic        z_valid, z_last, z_busy, z_done;
  logic        z_ready = 1'b1;

  interp_raster_seq #(.NUM_ATTR(3), .TILE_W(4), .TILE_H(2), .SETUP_LAT(0)) u_z (
    .clock(clock), .reset(reset),
    .poly_valid(z_poly_valid), .poly_ready(z_poly_ready), .attr_mask(z_mask),
    .tile_x0(z_x0), .tile_y0(z_y0),
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
    .scissor_en(1'b0), .sc_xmin(12'd0), .sc_xmax(12'd0), .sc_ymin(12'd0), .sc_ymax(12'd0),
`endif
    .setup_out(z_setup), .attr_sel(z_sel), .x_ps(z_x), .y_ps(z_y),
    .pix_valid(z_valid), .pix_ready(z_ready), .pix_last(z_last),
    .busy(z_busy), .done(z_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct packed {logic [11:0] x; logic [11:0] y; logic last;} pix_t;
  pix_t exp_q[$];

  // Reference raster order for one tile, filtered by the scissor window.
  function automatic void push_pixels(input logic [11:0] x0, input logic [11:0] y0);
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        pix_t p;
        bit   keep;
        p.x    = x0 + 12'(c);
        p.y    = y0 + 12'(r);
        p.last = (r == TH - 1) && (c == TW - 1);
        keep   = 1'b1;
`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
        if (sc_en)
          keep = ($signed(p.x) >= $signed(sc_xmin)) && ($signed(p.x) <= $signed(sc_xmax)) &&
                 ($signed(p.y) >= $signed(sc_ymin)) && ($signed(p.y) <= $signed(sc_ymax));
`endif
        if (keep) exp_q.push_back(p);
      end
    end
  endfunction

  // Downstream ready pattern: 0 always ready, 1 toggle, 2 random.
  int ready_mode = 0;
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Monitor: scoreboard pops on handshakes, hold, exclusivity, done timing.
  int   pix_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int   last_hs_cyc = 0, acc_cyc = 0;
  bit   hold_pend = 1'b0;
  pix_t hold_pix;
  always @(negedge clock) begin
    pix_t cur, e;
    cur = {x_ps, y_ps, pix_last};
    if (|setup_out) check("setup_excl_pix", {31'd0, pix_valid}, 32'd0);
    if (hold_pend) check("hold", {6'd0, pix_valid, cur}, {6'd0, 1'b1, hold_pix});
    hold_pend = pix_valid && !pix_ready;
    hold_pix  = cur;
    if (pix_valid && pix_ready) begin
      pix_cnt++;
      if (exp_q.size() == 0) check("sb_extra_pixel", exp_q.size(), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("pixel", {7'd0, cur}, {7'd0, e});
      end
    end
    if (pix_last && (!pix_valid || pix_ready)) last_hs_cyc = cyc;
    if (done) begin
      done_cnt++;
      check("done_after_last", cyc - last_hs_cyc, 32'd1);
    end
    if (poly_valid && poly_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {21'd0, poly_ready, setup_out, attr_sel, pix_valid, pix_last, busy, done},
          {21'd0, 1'b1, 10'd0});
    check({tag, "_xy"}, {8'd0, x_ps, y_ps}, 32'd0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check("done_seen", done_cnt - d0, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [11:0] x0;
    logic [11:0] y0;
    int          mode;
    int          first;
  } vec_t;
  vec_t vecs[5];

  // One polygon: per-cycle setup strobes, first-pixel cycle, full tile, done.
  task automatic run_poly(input vec_t v);
    int bits[$];
    int c, d0, p0;
    bit seen;
    for (int i = 0; i < NA; i++) if (v.mask[i]) bits.push_back(i);
    ready_mode = v.mode;
    push_pixels(v.x0, v.y0);
    d0 = done_cnt;
    p0 = pix_cnt;
    @(posedge clock); #1;
    check("idle_ready", {31'd0, poly_ready}, 32'd1);
    poly_valid = 1'b1; attr_mask = v.mask; tile_x0 = v.x0; tile_y0 = v.y0;
    @(posedge clock); #1;
    poly_valid = 1'b0; attr_mask = '0; tile_x0 = 12'hAAA; tile_y0 = 12'h555;
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      @(negedge clock);
      c++;
      if (c == 1) check("accept_ready_busy", {30'd0, poly_ready, busy}, 32'b01);
      if (c <= bits.size())
        check("setup_pulse", {26'd0, attr_sel, setup_out}, {26'd0, 2'(bits[c-1]), 4'(1 << bits[c-1])});
      else
        check("setup_quiet", {28'd0, setup_out}, 32'd0);
      if (pix_valid) seen = 1'b1;
    end
    check("first_pix_cycle", c, v.first);
    wait_done(d0, 6000);
    check("pix_count", pix_cnt - p0, TW * TH);
    check("sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, a0, n;
    vecs[0] = '{4'b1111, 12'h000, 12'h000, 0, 7};
    vecs[1] = '{4'b0000, 12'h123, 12'hF00, 0, 3};
    vecs[2] = '{4'b1010, 12'h7F0, 12'h010, 1, 5};
    vecs[3] = '{4'b0100, 12'hFF8, 12'hFFC, 2, 4};
    vecs[4] = '{4'b1001, 12'h005, 12'h007, 0, 5};

    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_poly(vecs[i]);

    // Reset during SCAN at pixel 100, then accept right after release.
    ready_mode = 0;
    push_pixels(12'h000, 12'h000);
    p0 = pix_cnt;
    @(posedge clock); #1;
    poly_valid = 1'b1; attr_mask = 4'b0001; tile_x0 = '0; tile_y0 = '0;
    @(posedge clock); #1;
    poly_valid = 1'b0;
    n = 0;
    while (pix_cnt - p0 < 100 && n < 400) begin
      @(negedge clock); #1;
      n++;
    end
    @(posedge clock); #2;
    check("pixel100_xy", {8'd0, x_ps, y_ps}, {8'd0, 12'd4, 12'd3});
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    @(posedge clock); #1;
    check_reset_values("held_reset");
    push_pixels(12'h100, 12'h200);
    p0 = pix_cnt;
    attr_mask = 4'b0010; tile_x0 = 12'h100; tile_y0 = 12'h200;
    poly_valid = 1'b1;
    reset = 1'b0;
    @(posedge clock); #1;
    poly_valid = 1'b0;
    check("post_reset_accept", {30'd0, poly_ready, busy}, 32'b01);
    wait_done(d0, 3000);
    check("post_reset_pix_count", pix_cnt - p0, TW * TH);
    check("post_reset_sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();

    // poly_valid held high: the second accept is 2 cycles after the last handshake.
    push_pixels(12'h040, 12'h040);
    push_pixels(12'h040, 12'h040);
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clock); #1;
    poly_valid = 1'b1; attr_mask = 4'b0000; tile_x0 = 12'h040; tile_y0 = 12'h040;
    n = 0;
    while (acc_cnt - a0 < 2 && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    check("b2b_second_accept", acc_cnt - a0, 32'd2);
    check("b2b_gap", acc_cyc - last_hs_cyc, 32'd2);
    @(posedge clock); #1;
    poly_valid = 1'b0;
    wait_done(d0 + 1, 3000);
    check("b2b_accepts", acc_cnt - a0, 32'd2);
    check("b2b_sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();

`ifdef INTERP_RASTER_SEQ_SCISSOR_EN
    // Scissor x 4..5, y 2: two pixels; done follows the skipped last pixel.
    sc_en = 1'b1; sc_xmin = 12'd4; sc_xmax = 12'd5; sc_ymin = 12'd2; sc_ymax = 12'd2;
    push_pixels(12'h000, 12'h000);
    check("sc_model_count", exp_q.size(), 32'd2);
    p0 = pix_cnt;
    @(posedge clock); #1;
    poly_valid = 1'b1; attr_mask = 4'b0000; tile_x0 = '0; tile_y0 = '0;
    @(posedge clock); #1;
    poly_valid = 1'b0;
    sc_en = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("sc_done_cycle", n, 32'd1027);
    check("sc_pix_count", pix_cnt - p0, 32'd2);
    check("sc_sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
`endif

    // Zero-latency instance, empty mask: pixel in cycle 1 at the origin.
    @(posedge clock); #1;
    z_poly_valid = 1'b1; z_mask = 3'b000; z_x0 = 12'h010; z_y0 = 12'h020;
    @(posedge clock); #1;
    z_poly_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("z_pixel", {6'd0, z_valid, z_x, z_y, z_last},
            {6'd0, 1'b1, 12'h010 + 12'(i % 4), 12'h020 + 12'(i / 4), 1'(i == 7)});
      if (i == 0) check("z_no_setup", {29'd0, z_setup}, 32'd0);
    end
    @(negedge clock);
    check("z_done", {30'd0, z_done, z_valid}, 32'b10);
    @(negedge clock);
    check("z_idle", {29'd0, z_poly_ready, z_done, z_busy}, 32'b100);

    // Zero-latency instance, mask 101: two strobes then scan in cycle 3.
    @(posedge clock); #1;
    z_poly_valid = 1'b1; z_mask = 3'b101; z_x0 = 12'hFFE; z_y0 = 12'h001;
    @(posedge clock); #1;
    z_poly_valid = 1'b0;
    @(negedge clock);
    check("z_setup_c1", {27'd0, z_valid, z_sel, z_setup}, {27'd0, 1'b0, 2'd0, 3'b001});
    @(negedge clock);
    check("z_setup_c2", {27'd0, z_valid, z_sel, z_setup}, {27'd0, 1'b0, 2'd2, 3'b100});
    @(negedge clock);
    check("z_scan_c3", {4'd0, z_valid, z_setup, z_x, z_y}, {4'd0, 1'b1, 3'b000, 12'hFFE, 12'h001});
    n = 0;
    while (!z_done && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("z_done_after_scan", {31'd0, z_done}, 32'd1);
    check("z_scan_cycles", n, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interp_raster_seq.md
Name: interp_raster_seq

Overview:
Sequencer that drives the bank of PVR plane-equation interpolators for one polygon within one tile.
- Accepts a polygon from the triangle setup front end and pulses each enabled interpolator's `setup` in turn.
- Waits out the setup settle time, then raster-scans the tile, driving `x_ps`/`y_ps` to all interpolators with a valid/ready pixel handshake toward the shading stage.
- Sits between the polygon parameter fetch and the interpolator bank, and owns the interpolators' timing.

Parameters:
- NUM_ATTR, 4, number of interpolator instances (Z, U, V, colour, ...) sequenced; range 1..8.
- TILE_W, 32, tile width in pixels; power of two, 2..64.
- TILE_H, 32, tile height in pixels; power of two, 2..64.
- SETUP_LAT, 2, idle cycles after the last setup pulse before the first pixel; range 0..15.

Ports:
- clock, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- poly_valid, in, 1, a polygon's vertex data is stable on the interpolator inputs.
- poly_ready, out, 1, sequencer is idle and can accept a polygon.
- attr_mask, in, NUM_ATTR, interpolators to set up for this polygon; sampled at accept.
- tile_x0, in, 12 signed, tile origin X; sampled at accept.
- tile_y0, in, 12 signed, tile origin Y; sampled at accept.
- setup_out, out, NUM_ATTR, one-hot single-cycle setup strobe, one bit per interpolator.
- attr_sel, out, clog2(NUM_ATTR) (min 1), index of the interpolator currently being set up.
- x_ps, out, 12 signed, pixel X to all interpolators.
- y_ps, out, 12 signed, pixel Y to all interpolators.
- pix_valid, out, 1, `x_ps`/`y_ps` hold a pixel to shade.
- pix_ready, in, 1, downstream consumes the pixel.
- pix_last, out, 1, current pixel is the final pixel of the tile.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, single-cycle pulse the cycle after the last pixel handshake.

Behaviour:
- Reset values: poly_ready=1; setup_out=0; attr_sel=0; x_ps=0; y_ps=0; pix_valid=0; pix_last=0; busy=0; done=0. FSM enters IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. No `done` pulse is issued, and the polygon is discarded.
- Accept: a polygon is accepted when `poly_valid && poly_ready` at a rising edge (cycle 0). `attr_mask`, `tile_x0` and `tile_y0` are registered at that edge. `poly_ready` drops in cycle 1.
- FSM states: IDLE, SETUP, WAIT, SCAN, DONE.
- IDLE -> SETUP on accept if the registered mask is nonzero. IDLE -> WAIT if the mask is zero (no setup pulses).
- SETUP:
  - Each cycle, assert `setup_out` for the lowest-index pending mask bit only, with `attr_sel` set to that index, then clear that bit.
  - Move to WAIT in the cycle after the last pending bit is pulsed.
  - Example: mask 4'b1010 pulses bit 1 in cycle 1 and bit 3 in cycle 2.
- WAIT: count SETUP_LAT cycles (0 means zero cycles in WAIT), then go to SCAN with x_ps=tile_x0 and y_ps=tile_y0.
- SCAN:
  - `pix_valid` is high. `x_ps`, `y_ps` and `pix_last` hold stable until `pix_ready`.
  - On a handshake, x advances by 1. At column TILE_W-1, x returns to tile_x0 and y advances by 1.
  - Row-major order, TILE_W*TILE_H pixels in total.
  - `pix_last` is high when at column TILE_W-1 and row TILE_H-1. A handshake on the last pixel moves the FSM to DONE.
- Coordinate arithmetic is 12-bit two's complement and wraps modulo 4096. An origin of 12'h7F0 with TILE_W=32 yields x values 0x7F0..0x7FF then 0x800..0x80F, with no saturation.
- DONE: pulse `done` for one cycle, then return to IDLE. `poly_ready` is high again in the following cycle, so back-to-back polygons have a 2-cycle gap after the last pixel.
- `poly_valid` while busy is ignored; it is not queued.
- `pix_ready` outside SCAN is ignored.
- setup_out is never asserted in the same cycle as `pix_valid`.

Optional Feature:
- Macro: INTERP_RASTER_SEQ_SCISSOR_EN.
- When defined, adds these inputs, sampled at accept:
  - scissor_en (1 bit)
  - sc_xmin, sc_xmax, sc_ymin, sc_ymax (12-bit signed, inclusive)
- With scissor_en set, SCAN pixels outside the rectangle are skipped: the counter advances one pixel per cycle with `pix_valid` low, so no handshake is needed.
- If the last tile pixel is outside the rectangle, DONE follows the cycle after it is skipped.
- A rectangle covering no pixel produces no `pix_valid` at all, and `done` still pulses.
- When the macro is undefined, the inputs do not exist and every tile pixel is emitted.

Test Plan:
- Defaults, mask 4'b1111, origin (0,0), pix_ready=1 -> setup_out 0001,0010,0100,1000 in cycles 1-4; first pix_valid in cycle 7 at (0,0); 1024 pixels; pix_last at (31,31); done one cycle later.
- Mask 4'b0000, SETUP_LAT=0 -> no setup_out pulses; pix_valid in cycle 1 at the origin.
- Origin (0x7F0,0x010), pix_ready toggling 1/0 -> the x sequence wraps 0x7FF->0x800; each coordinate is held while pix_ready=0; the count is exactly 1024.
- Reset pulsed during SCAN at pixel 100 -> all outputs return to reset values asynchronously; no done pulse; a new polygon is accepted the cycle after reset is released.
- poly_valid held high throughout -> a second accept occurs exactly 2 cycles after the last pixel handshake.
- Scissor build, rectangle x 4..5, y 2 -> exactly 2 pixels, (4,2) and (5,2); done pulses the cycle after pixel (31,31) is skipped.
